// File: rtl/generic_sc_fifo.sv
// rtl/generic_sc_fifo.sv - single-clock show-ahead FIFO with word count and full/empty flags
module generic_sc_fifo #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W:0]   usedw_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   usedw;

  logic wr_acc;
  logic rd_acc;
  logic empty_flag;
  logic full_flag;

  // Flags come straight from the registered count, so they move on the same
  // edge that accepts an operation.
  assign empty_flag = (usedw == '0);
  assign full_flag  = (usedw == FULL_CNT);

  // Acceptance is gated by the current flags only: a read on empty or a write
  // on full is dropped even when the opposite operation is requested, since
  // the read-side head is not available to bypass a full or empty buffer.
  always_comb begin
    wr_acc = 1'b0;
    rd_acc = 1'b0;
    if (!rst_i) begin
      wr_acc = wr_en_i && !full_flag;
      rd_acc = rd_en_i && !empty_flag;
    end
  end

  // Storage array; deliberately not reset, stale words are simply unreachable.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointer registers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Occupancy counter: simultaneous accepted write and read cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      usedw <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   usedw <= usedw + CNT_ONE;
        2'b01:   usedw <= usedw - CNT_ONE;
        default: usedw <= usedw;
      endcase
    end
  end

  // Show-ahead head word: combinational read at the read pointer, so a word
  // written into an empty FIFO is visible the cycle after its write edge.
  always_comb begin
    data_o = mem[rd_ptr];
  end

  assign usedw_o = usedw;
  assign empty_o = empty_flag;
  assign full_o  = full_flag;

endmodule

// File: tb/tb_generic_sc_fifo.sv
// tb/tb_generic_sc_fifo.sv - directed self-checking bench for generic_sc_fifo
module tb_generic_sc_fifo;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;

  logic              clk_i;
  logic              rst_i;
  logic              wr_en_i;
  logic [DATA_W-1:0] data_i;
  logic              rd_en_i;
  logic [DATA_W-1:0] data_o;
  logic [ADDR_W:0]   usedw_o;
  logic              empty_o;
  logic              full_o;

  int n_checks;
  int n_errors;

  generic_sc_fifo #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en_i (wr_en_i),
    .data_i  (data_i),
    .rd_en_i (rd_en_i),
    .data_o  (data_o),
    .usedw_o (usedw_o),
    .empty_o (empty_o),
    .full_o  (full_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, then settle 1 time unit before sampling/driving
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt);
    chk({tag, "_usedw"}, 32'(usedw_o), 32'(cnt));
    chk({tag, "_empty"}, 32'(empty_o), 32'(cnt == 0));
    chk({tag, "_full"},  32'(full_o),  32'(cnt == DEPTH));
  endtask

  task automatic push(input logic [7:0] d);
    wr_en_i = 1'b1;
    data_i  = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  // check the show-ahead head before popping it
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, 32'(data_o), 32'(exp));
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
  endtask

  function automatic logic [7:0] pat(input int r, input int i);
    pat = 8'((r * 53 + i * 29 + 7) & 8'hFF);
  endfunction

  initial begin
    int sizes [4];
    n_checks = 0;
    n_errors = 0;
    rst_i   = 1'b1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    data_i  = '0;
    sizes[0] = 31; sizes[1] = 8; sizes[2] = 31; sizes[3] = 8;

    tick();
    tick();
    rst_i = 1'b0;
    chk_state("reset", 0);

    // empty behaviour: reads on empty are dropped
    rd_en_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_state("rd_empty", 0);
    end
    // write+read on empty: write accepted, read dropped
    wr_en_i = 1'b1;
    data_i  = 8'h77;
    tick();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    chk_state("wr_rd_empty", 1);
    pop_chk("head_77", 8'h77);
    chk_state("after_77", 0);
    push(8'hA5);
    chk("fwft_a5", 32'(data_o), 32'h0000_00A5);
    chk_state("after_a5", 1);
    pop_chk("pop_a5", 8'hA5);
    chk_state("drained_a5", 0);

    // pointer wrap: repeated fill/drain rounds
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < sizes[r]; i++) begin
        push(pat(r, i));
      end
      chk_state("wrap_fill", sizes[r]);
      rd_en_i = 1'b1;
      for (int i = 0; i < sizes[r]; i++) begin
        chk("wrap_data", 32'(data_o), 32'(pat(r, i)));
        tick();
      end
      rd_en_i = 1'b0;
      chk_state("wrap_drain", 0);
    end

    // full behaviour
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(8'h40 + i));
    end
    chk_state("full32", 32);
    push(8'hFF);
    chk_state("full_drop", 32);
    // write+read on full: read accepted, write dropped
    wr_en_i = 1'b1;
    rd_en_i = 1'b1;
    data_i  = 8'hEE;
    chk("full_head", 32'(data_o), 32'h0000_0040);
    tick();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    chk_state("full_wr_rd", 31);
    rd_en_i = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      chk("full_drain", 32'(data_o), 32'(8'(8'h40 + i)));
      tick();
    end
    rd_en_i = 1'b0;
    chk_state("full_empty", 0);

    // simultaneous write and read with 4 words stored
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h10 + i));
    end
    chk_state("sim_pre", 4);
    wr_en_i = 1'b1;
    rd_en_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_i = 8'(8'h20 + k);
      chk("sim_data", 32'(data_o), (k < 4) ? 32'(8'h10 + k) : 32'(8'h20 + k - 4));
      tick();
      chk("sim_usedw", 32'(usedw_o), 32'd4);
    end
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    for (int i = 6; i < 10; i++) begin
      pop_chk("sim_tail", 8'(8'h20 + i));
    end
    chk_state("sim_empty", 0);

    // reset mid-operation, with a write requested in the reset cycle
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h80 + i));
    end
    chk_state("pre_rst", 20);
    rst_i   = 1'b1;
    wr_en_i = 1'b1;
    data_i  = 8'h99;
    tick();
    rst_i   = 1'b0;
    wr_en_i = 1'b0;
    chk_state("mid_rst", 0);
    push(8'h3C);
    chk_state("post_rst_wr", 1);
    pop_chk("post_rst_3c", 8'h3C);
    chk_state("post_rst_empty", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
